multi_cycle_adder: RTL

MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

---
 rtl/multi_cycle_adder.sv | 112 +++++++++++
 1 files changed

// File: rtl/multi_cycle_adder.sv
// Sequential chunked adder/subtractor: CHUNK bits per clock,
// result, carry and signed overflow published once on completion.
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             input_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             output_carry,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] part_q, part_d;
    logic             carry_q;
    logic [IW-1:0]    idx_q;

    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic             co_c;
    logic             ci_msb;
    logic             last;

    // b_q already holds ~b for subtract, so the chunk adder is mode-agnostic
    always_comb begin
        a_c = a_q[idx_q*CHUNK +: CHUNK];
        b_c = b_q[idx_q*CHUNK +: CHUNK];
        {co_c, s_c} = {1'b0, a_c} + {1'b0, b_c}
                    + (CHUNK+1)'(carry_q);
        ci_msb = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
        part_d = part_q;
        part_d[idx_q*CHUNK +: CHUNK] = s_c;
        last = (idx_q == IW'(NCHUNK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            part_q       <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            sum          <= '0;
            output_carry <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= mode ? ~b : b;
                        carry_q <= mode | input_carry;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    part_q  <= part_d;
                    carry_q <= co_c;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        sum          <= part_d;
                        output_carry <= co_c;
                        overflow     <= ci_msb ^ co_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
